// File: rtl/cc_unit.sv
// LC-3 condition-code unit: NZP register, branch-enable register and a
// LIFO save/restore stack for CC across interrupt entry and RTI.
module cc_unit #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus_i,
    input  logic             ld_cc,
    input  logic             ld_ben,
    input  logic [2:0]       ir_nzp,
    input  logic             cc_push,
    input  logic             cc_pop,
    output logic [2:0]       nzp,
    output logic             ben,
    output logic [CW-1:0]    stack_count,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             err
);

    function automatic logic [2:0] classify(input logic signed [WIDTH-1:0] v);
        if (v < 0) begin
            return 3'b100;
        end else if (v == '0) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    logic [2:0]    nzp_q, nzp_d;
    logic          ben_q, ben_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [2:0]    stack_q [DEPTH];
    logic [2:0]    stack_d [DEPTH];

    logic       full, empty;
    logic       push_ok, pop_ok, illegal;
    logic [2:0] stack_top;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = cc_push && !cc_pop && !full;
    assign pop_ok  = cc_pop && !cc_push && !empty;
    assign illegal = (cc_push && cc_pop) ||
                     (cc_push && !cc_pop && full) ||
                     (cc_pop && !cc_push && empty);

    // Top-of-stack mux; entry count_q-1 is the most recent save.
    always_comb begin
        stack_top = 3'b000;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i + 1)) begin
                stack_top = stack_q[i];
            end
        end
    end

    always_comb begin
        nzp_d   = nzp_q;
        ben_d   = ben_q;
        count_d = count_q;
        err_d   = err_q;

        // BEN samples the pre-edge NZP, so a same-cycle ld_cc does not leak in.
        if (ld_ben) begin
            ben_d = |(ir_nzp & nzp_q);
        end

        if (pop_ok) begin
            nzp_d = stack_top;
        end else if (ld_cc) begin
            nzp_d = classify(bus_i);
        end

        if (push_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok) begin
            count_d = count_q - CW'(1);
        end

        if (illegal) begin
            err_d = 1'b1;
        end
    end

    // Push stores the pre-edge NZP even when ld_cc updates it in the same cycle.
    always_comb begin
        stack_d = stack_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok && (count_q == CW'(i))) begin
                stack_d[i] = nzp_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nzp_q   <= 3'b000;
            ben_q   <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            nzp_q   <= nzp_d;
            ben_q   <= ben_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Stack storage carries no reset; only entries below count_q are ever read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= stack_d[i];
        end
    end

    assign nzp         = nzp_q;
    assign ben         = ben_q;
    assign stack_count = count_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign err         = err_q;

endmodule

// File: tb/tb_cc_unit.sv
// Self-checking bench for cc_unit: directed steps plus randomized traffic
// compared against a queue-based reference model.
module tb_cc_unit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] bus_i;
    logic             ld_cc;
    logic             ld_ben;
    logic [2:0]       ir_nzp;
    logic             cc_push;
    logic             cc_pop;
    logic [2:0]       nzp;
    logic             ben;
    logic [CW-1:0]    stack_count;
    logic             stack_full;
    logic             stack_empty;
    logic             err;

    cc_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_i       (bus_i),
        .ld_cc       (ld_cc),
        .ld_ben      (ld_ben),
        .ir_nzp      (ir_nzp),
        .cc_push     (cc_push),
        .cc_pop      (cc_pop),
        .nzp         (nzp),
        .ben         (ben),
        .stack_count (stack_count),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [2:0] m_nzp;
    logic       m_ben;
    logic       m_err;
    logic [2:0] m_stk[$];

    function automatic logic [2:0] ref_cls(input logic [WIDTH-1:0] b);
        int signed v;
        v = int'($signed(b));
        if (v < 0) return 3'b100;
        if (v == 0) return 3'b010;
        return 3'b001;
    endfunction

    task automatic model_reset();
        m_nzp = 3'b000;
        m_ben = 1'b0;
        m_err = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_edge(input logic lc, input logic [WIDTH-1:0] b, input logic lb,
                              input logic [2:0] ir, input logic pu, input logic po);
        logic [2:0] old;
        bit can_push, can_pop;
        old      = m_nzp;
        can_push = pu && !po && (m_stk.size() < DEPTH);
        can_pop  = po && !pu && (m_stk.size() > 0);
        if (lb) m_ben = |(ir & old);
        if ((pu && po) || (pu && !po && !can_push) || (po && !pu && !can_pop)) m_err = 1'b1;
        if (can_pop) m_nzp = m_stk.pop_back();
        else if (lc) m_nzp = ref_cls(b);
        if (can_push) m_stk.push_back(old);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".nzp"},   32'(nzp),         32'(m_nzp));
        chk({tag, ".ben"},   32'(ben),         32'(m_ben));
        chk({tag, ".count"}, 32'(stack_count), 32'(m_stk.size()));
        chk({tag, ".full"},  32'(stack_full),  32'(m_stk.size() == DEPTH));
        chk({tag, ".empty"}, 32'(stack_empty), 32'(m_stk.size() == 0));
        chk({tag, ".err"},   32'(err),         32'(m_err));
    endtask

    task automatic step(input string tag, input logic lc, input logic [WIDTH-1:0] b,
                        input logic lb, input logic [2:0] ir, input logic pu, input logic po);
        ld_cc   = lc;
        bus_i   = b;
        ld_ben  = lb;
        ir_nzp  = ir;
        cc_push = pu;
        cc_pop  = po;
        @(posedge clk);
        model_edge(lc, b, lb, ir, pu, po);
        #1;
        check_all(tag);
        ld_cc   = 1'b0;
        ld_ben  = 1'b0;
        cc_push = 1'b0;
        cc_pop  = 1'b0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #4 reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        bus_i   = '0;
        ld_cc   = 1'b0;
        ld_ben  = 1'b0;
        ir_nzp  = 3'b000;
        cc_push = 1'b0;
        cc_pop  = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        #13 reset = 1'b1;

        // Classification
        step("ld_neg",  1, 16'h8000, 0, 3'b000, 0, 0);
        step("ld_zero", 1, 16'h0000, 0, 3'b000, 0, 0);
        step("ld_one",  1, 16'h0001, 0, 3'b000, 0, 0);
        step("ld_max",  1, 16'h7FFF, 0, 3'b000, 0, 0);

        // BEN
        step("z_set",     1, 16'h0000, 0, 3'b000, 0, 0);
        step("ben_010",   0, 16'h0000, 1, 3'b010, 0, 0);
        step("ben_101",   0, 16'h0000, 1, 3'b101, 0, 0);
        step("ben_ldcc",  1, 16'hFFFF, 1, 3'b010, 0, 0);
        step("ben_000",   0, 16'h0000, 1, 3'b000, 0, 0);
        step("ben_111",   0, 16'h0000, 1, 3'b111, 0, 0);

        // Fill the stack with 001,010,100,001
        step("p_ld",   1, 16'h0001, 0, 3'b000, 0, 0);
        step("push1",  1, 16'h0000, 0, 3'b000, 1, 0);
        step("push2",  1, 16'h8000, 0, 3'b000, 1, 0);
        step("push3",  1, 16'h0001, 0, 3'b000, 1, 0);
        step("push4",  0, 16'h0000, 0, 3'b000, 1, 0);
        step("push5",  0, 16'h0000, 0, 3'b000, 1, 0);
        step("pop1",   0, 16'h0000, 0, 3'b000, 0, 1);
        step("pop2",   0, 16'h0000, 0, 3'b000, 0, 1);
        step("pop3",   0, 16'h0000, 0, 3'b000, 0, 1);
        step("pop4",   0, 16'h0000, 0, 3'b000, 0, 1);

        // Illegal operations
        step("pop_empty", 1, 16'h0000, 0, 3'b000, 0, 1);
        step("pu_a",      0, 16'h0000, 0, 3'b000, 1, 0);
        step("pu_b",      0, 16'h0000, 0, 3'b000, 1, 0);
        step("push_pop",  0, 16'h0000, 0, 3'b000, 1, 1);

        // Pop priority over ld_cc; push stores the old NZP
        async_reset("rst1");
        step("pr_ld1",  1, 16'h0001, 0, 3'b000, 0, 0);
        step("pr_push", 0, 16'h0000, 0, 3'b000, 1, 0);
        step("pr_ld4",  1, 16'h8000, 0, 3'b000, 0, 0);
        step("pr_pop",  1, 16'h0005, 0, 3'b000, 0, 1);
        step("pr_ld4b", 1, 16'h8000, 0, 3'b000, 0, 0);
        step("pr_pshl", 1, 16'h0000, 0, 3'b000, 1, 0);
        step("pr_popb", 0, 16'h0000, 0, 3'b000, 0, 1);

        // Reset mid-operation
        step("mr_ld",   1, 16'h8000, 1, 3'b100, 0, 0);
        step("mr_pu1",  0, 16'h0000, 1, 3'b100, 1, 0);
        step("mr_pu2",  0, 16'h0000, 0, 3'b000, 1, 0);
        step("mr_bad",  0, 16'h0000, 0, 3'b000, 1, 1);
        async_reset("rst2");
        step("mr_pop",  0, 16'h0000, 0, 3'b000, 0, 1);

        // Randomized traffic
        async_reset("rst3");
        for (int i = 0; i < 400; i++) begin
            logic [WIDTH-1:0] b;
            case ($urandom_range(3))
                0:       b = '0;
                1:       b = WIDTH'($urandom) | 16'h8000;
                default: b = WIDTH'($urandom);
            endcase
            step("rand", 1'($urandom_range(1)), b, 1'($urandom_range(1)),
                 3'($urandom), ($urandom_range(2) == 0), ($urandom_range(2) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
